// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the hazard controller
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enable-driven counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline enable/flush control, halt drain FSM
// and stall/flush performance counters.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_MEM,
  input  logic             dmemWEN_MEM,
  input  logic             halt_MEM,
  input  logic             memtoReg_EX,
  input  logic             RegWr_EX,
  input  regbits_t         wsel_EX,
  input  regbits_t         rs_ID,
  input  regbits_t         rt_ID,
  input  logic             uses_rt_ID,
  input  logic             branch_taken_EX,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  hz_state_t  state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic       halt_q;
  logic       dwait, loaduse;

  assign dwait   = (dmemREN_MEM | dmemWEN_MEM) & ~dhit;
  assign loaduse = memtoReg_EX & RegWr_EX & (wsel_EX != '0)
                 & ((wsel_EX == rs_ID) | (uses_rt_ID & (wsel_EX == rt_ID)));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    case (state_q)
      RUN: begin
        // A pending data access freezes everything, including halt entry.
        if (!dwait) begin
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (branch_taken_EX) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (loaduse || !ihit) begin
            idex_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
          if (halt_MEM) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        if (drain_q == 4'd0) state_d = HALTED;
        else                 drain_d = drain_q - 4'd1;
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      drain_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      halt_q  <= halt_q | (state_d == HALTED);
    end
  end

  assign halt_out = halt_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en_i  ((state_q == RUN) & ~pc_en),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en_i  (ifid_flush),
    .cnt_o (flush_cnt)
  );

endmodule
